y86_decode_stage: RTL and testbench

- Pipelined decode stage feeding the Y86 register file.
- Holds the D pipeline register, which is loaded from fetch. From it, the stage combinationally drives the register-file read IDs (srcA/srcB).
- Registers the decoded fields into the E pipeline register on the same edge the register file latches valA/valB, so both reach execute aligned.
- Tracks machine status and stops accepting instructions after a halt or an invalid instruction.

---
 rtl/y86_decode_stage.sv | 175 +++++++++++++++++
 tb/tb_y86_decode_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_decode_stage.sv
// Y86 decode stage: D pipeline register, register-file read IDs, E pipeline
// register and sticky machine status (AOK/HLT/INS).
module y86_decode_stage #(
  parameter int         WIDTH = 32,
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] RSP   = 4'h4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             f_valid,
  input  logic [3:0]       f_icode,
  input  logic [3:0]       f_ifun,
  input  logic [3:0]       f_rA,
  input  logic [3:0]       f_rB,
  input  logic [WIDTH-1:0] f_valC,
  input  logic [WIDTH-1:0] f_valP,
  input  logic             d_stall,
  input  logic             d_bubble,
  input  logic             e_bubble,
  output logic             f_ready,
  output logic [3:0]       d_srcA,
  output logic [3:0]       d_srcB,
  output logic             e_valid,
  output logic [3:0]       e_icode,
  output logic [3:0]       e_ifun,
  output logic [WIDTH-1:0] e_valC,
  output logic [WIDTH-1:0] e_valP,
  output logic [3:0]       e_srcA,
  output logic [3:0]       e_srcB,
  output logic [3:0]       e_dstE,
  output logic [3:0]       e_dstM,
  output logic [1:0]       stat
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_INS = 2'd2;

  logic             r_d_valid;
  logic [3:0]       r_d_icode;
  logic [3:0]       r_d_ifun;
  logic [3:0]       r_d_rA;
  logic [3:0]       r_d_rB;
  logic [WIDTH-1:0] r_d_valC;
  logic [WIDTH-1:0] r_d_valP;
  logic             r_halted;
  logic [1:0]       r_stat;

  logic [3:0] w_srcA;
  logic [3:0] w_srcB;
  logic [3:0] w_dstE;
  logic [3:0] w_dstM;
  logic       w_load_e;

  assign f_ready  = !d_stall && !r_halted;
  assign d_srcA   = w_srcA;
  assign d_srcB   = w_srcB;
  assign stat     = r_stat;
  assign w_load_e = !e_bubble && !r_halted && r_d_valid;

  // Register IDs decoded from the D register; an empty D slot names no register.
  always_comb begin
    w_srcA = RNONE;
    w_srcB = RNONE;
    w_dstE = RNONE;
    w_dstM = RNONE;
    if (r_d_valid) begin
      case (r_d_icode)
        I_RRMOVQ: begin w_srcA = r_d_rA; w_dstE = r_d_rB; end
        I_IRMOVQ: begin w_dstE = r_d_rB; end
        I_RMMOVQ: begin w_srcA = r_d_rA; w_srcB = r_d_rB; end
        I_MRMOVQ: begin w_srcB = r_d_rB; w_dstM = r_d_rA; end
        I_OPQ:    begin w_srcA = r_d_rA; w_srcB = r_d_rB; w_dstE = r_d_rB; end
        I_CALL:   begin w_srcB = RSP;    w_dstE = RSP; end
        I_RET:    begin w_srcA = RSP;    w_srcB = RSP;    w_dstE = RSP; end
        I_PUSHQ:  begin w_srcA = r_d_rA; w_srcB = RSP;    w_dstE = RSP; end
        I_POPQ:   begin w_srcA = RSP;    w_srcB = RSP;    w_dstE = RSP; w_dstM = r_d_rA; end
        default:  begin w_srcA = RNONE; end
      endcase
    end else begin
      w_srcA = RNONE;
    end
  end

  // D pipeline register: stall beats bubble; a halted machine only takes bubbles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_d_valid <= 1'b0;
      r_d_icode <= I_NOP;
      r_d_ifun  <= 4'h0;
      r_d_rA    <= RNONE;
      r_d_rB    <= RNONE;
      r_d_valC  <= '0;
      r_d_valP  <= '0;
    end else if (d_stall) begin
      r_d_valid <= r_d_valid;
    end else if (d_bubble || r_halted || !f_valid) begin
      r_d_valid <= 1'b0;
      r_d_icode <= I_NOP;
      r_d_ifun  <= 4'h0;
      r_d_rA    <= RNONE;
      r_d_rB    <= RNONE;
      r_d_valC  <= '0;
      r_d_valP  <= '0;
    end else begin
      r_d_valid <= 1'b1;
      r_d_icode <= f_icode;
      r_d_ifun  <= f_ifun;
      r_d_rA    <= f_rA;
      r_d_rB    <= f_rB;
      r_d_valC  <= f_valC;
      r_d_valP  <= f_valP;
    end
  end

  // E pipeline register and status; a halting instruction still enters E.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      e_valid  <= 1'b0;
      e_icode  <= I_NOP;
      e_ifun   <= 4'h0;
      e_valC   <= '0;
      e_valP   <= '0;
      e_srcA   <= RNONE;
      e_srcB   <= RNONE;
      e_dstE   <= RNONE;
      e_dstM   <= RNONE;
      r_stat   <= S_AOK;
      r_halted <= 1'b0;
    end else if (w_load_e) begin
      e_valid <= 1'b1;
      e_icode <= r_d_icode;
      e_ifun  <= r_d_ifun;
      e_valC  <= r_d_valC;
      e_valP  <= r_d_valP;
      e_srcA  <= w_srcA;
      e_srcB  <= w_srcB;
      e_dstE  <= w_dstE;
      e_dstM  <= w_dstM;
      if (r_d_icode == I_HALT) begin
        r_stat   <= S_HLT;
        r_halted <= 1'b1;
      end else if (r_d_icode > I_POPQ) begin
        r_stat   <= S_INS;
        r_halted <= 1'b1;
      end else begin
        r_stat   <= r_stat;
        r_halted <= r_halted;
      end
    end else begin
      e_valid <= 1'b0;
      e_icode <= I_NOP;
      e_ifun  <= 4'h0;
      e_valC  <= '0;
      e_valP  <= '0;
      e_srcA  <= RNONE;
      e_srcB  <= RNONE;
      e_dstE  <= RNONE;
      e_dstM  <= RNONE;
    end
  end

endmodule

// File: tb/tb_y86_decode_stage.sv
// Self-checking bench for y86_decode_stage: directed table, hand sequences
// for stall/halt/invalid/async reset, and randomized traffic against a model.
module tb_y86_decode_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        f_valid = 1'b0;
  logic [3:0]  f_icode = 4'h1, f_ifun = 4'h0, f_rA = 4'hF, f_rB = 4'hF;
  logic [31:0] f_valC = 32'h0, f_valP = 32'h0;
  logic        d_stall = 1'b0, d_bubble = 1'b0, e_bubble = 1'b0;
  logic        f_ready, e_valid;
  logic [3:0]  d_srcA, d_srcB, e_icode, e_ifun, e_srcA, e_srcB, e_dstE, e_dstM;
  logic [31:0] e_valC, e_valP;
  logic [1:0]  stat;

  int n_vec = 0;
  int n_err = 0;

  y86_decode_stage #(.WIDTH(32), .RNONE(4'hF), .RSP(4'h4)) dut (
    .clock(clock), .reset(reset), .f_valid(f_valid), .f_icode(f_icode),
    .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
    .d_stall(d_stall), .d_bubble(d_bubble), .e_bubble(e_bubble),
    .f_ready(f_ready), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_valid(e_valid),
    .e_icode(e_icode), .e_ifun(e_ifun), .e_valC(e_valC), .e_valP(e_valP),
    .e_srcA(e_srcA), .e_srcB(e_srcB), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .stat(stat));

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct {
    logic v; logic [3:0] ic, fn, ra, rb; logic [31:0] c, p;
  } instr_t;
  typedef struct {
    logic v; logic [3:0] ic, fn, sa, sb, de, dm; logic [31:0] c, p;
  } e_t;

  instr_t m_d;
  e_t     m_e;
  logic [1:0] m_stat;
  logic   m_halt;

  function automatic instr_t bubble_d();
    instr_t b;
    b.v = 1'b0; b.ic = 4'h1; b.fn = 4'h0; b.ra = 4'hF; b.rb = 4'hF;
    b.c = 32'h0; b.p = 32'h0;
    return b;
  endfunction

  function automatic e_t bubble_e();
    e_t b;
    b.v = 1'b0; b.ic = 4'h1; b.fn = 4'h0; b.sa = 4'hF; b.sb = 4'hF;
    b.de = 4'hF; b.dm = 4'hF; b.c = 32'h0; b.p = 32'h0;
    return b;
  endfunction

  // Instruction roles by opcode: which operand fields each one reads/writes.
  function automatic logic [3:0] m_srcA(instr_t d);
    if (!d.v) return 4'hF;
    if (d.ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return d.ra;
    if (d.ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_srcB(instr_t d);
    if (!d.v) return 4'hF;
    if (d.ic inside {4'h4, 4'h5, 4'h6}) return d.rb;
    if (d.ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_dstE(instr_t d);
    if (!d.v) return 4'hF;
    if (d.ic inside {4'h2, 4'h3, 4'h6}) return d.rb;
    if (d.ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_dstM(instr_t d);
    if (!d.v) return 4'hF;
    if (d.ic inside {4'h5, 4'hB}) return d.ra;
    return 4'hF;
  endfunction

  task automatic model_reset();
    m_d = bubble_d(); m_e = bubble_e(); m_stat = 2'd0; m_halt = 1'b0;
  endtask

  task automatic model_clock();
    instr_t nd; e_t ne; logic [1:0] ns; logic nh;
    nd = m_d; ns = m_stat; nh = m_halt;
    if (e_bubble || m_halt || !m_d.v) ne = bubble_e();
    else begin
      ne.v = 1'b1; ne.ic = m_d.ic; ne.fn = m_d.fn; ne.c = m_d.c; ne.p = m_d.p;
      ne.sa = m_srcA(m_d); ne.sb = m_srcB(m_d); ne.de = m_dstE(m_d); ne.dm = m_dstM(m_d);
      if (m_d.ic == 4'h0) begin ns = 2'd1; nh = 1'b1; end
      else if (m_d.ic > 4'hB) begin ns = 2'd2; nh = 1'b1; end
    end
    if (d_stall) nd = m_d;
    else if (d_bubble || m_halt || !f_valid) nd = bubble_d();
    else begin
      nd.v = 1'b1; nd.ic = f_icode; nd.fn = f_ifun; nd.ra = f_rA; nd.rb = f_rB;
      nd.c = f_valC; nd.p = f_valP;
    end
    m_d = nd; m_e = ne; m_stat = ns; m_halt = nh;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".f_ready"}, {31'h0, f_ready}, {31'h0, (!d_stall && !m_halt)});
    chk({tag, ".d_srcA"}, {28'h0, d_srcA}, {28'h0, m_srcA(m_d)});
    chk({tag, ".d_srcB"}, {28'h0, d_srcB}, {28'h0, m_srcB(m_d)});
    chk({tag, ".e_valid"}, {31'h0, e_valid}, {31'h0, m_e.v});
    chk({tag, ".e_icode_ifun"}, {24'h0, e_icode, e_ifun}, {24'h0, m_e.ic, m_e.fn});
    chk({tag, ".e_valC"}, e_valC, m_e.c);
    chk({tag, ".e_valP"}, e_valP, m_e.p);
    chk({tag, ".e_ids"}, {16'h0, e_srcA, e_srcB, e_dstE, e_dstM},
        {16'h0, m_e.sa, m_e.sb, m_e.de, m_e.dm});
    chk({tag, ".stat"}, {30'h0, stat}, {30'h0, m_stat});
  endtask

  // One clock: model follows the same edge, outputs sampled 1 ns later.
  task automatic cycle();
    @(posedge clock);
    if (!reset) model_reset(); else model_clock();
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                       input logic [3:0] rb, input logic st, input logic db, input logic eb);
    f_valid = v; f_icode = ic; f_ifun = ic ^ 4'h5; f_rA = ra; f_rB = rb;
    f_valC = {ic, ra, rb, 20'h0ABC1}; f_valP = {20'h0, ic, ra, rb};
    d_stall = st; d_bubble = db; e_bubble = eb;
  endtask

  task automatic idle();
    drive(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 reset = 1'b0;
    #1 model_reset();
    check_model(tag);
    @(negedge clock) reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0] ic, ra, rb;
    logic [3:0] sa, sb, de, dm;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // icode, rA, rB -> expected srcA, srcB, dstE, dstM
    tbl[0]  = '{4'h6, 4'h1, 4'h2, 4'h1, 4'h2, 4'h2, 4'hF}; // OPq
    tbl[1]  = '{4'hA, 4'h3, 4'hF, 4'h3, 4'h4, 4'h4, 4'hF}; // pushq
    tbl[2]  = '{4'hB, 4'h5, 4'hF, 4'h4, 4'h4, 4'h4, 4'h5}; // popq
    tbl[3]  = '{4'h2, 4'h1, 4'h7, 4'h1, 4'hF, 4'h7, 4'hF}; // rrmovq
    tbl[4]  = '{4'h3, 4'hF, 4'h3, 4'hF, 4'hF, 4'h3, 4'hF}; // irmovq
    tbl[5]  = '{4'h4, 4'h2, 4'h5, 4'h2, 4'h5, 4'hF, 4'hF}; // rmmovq
    tbl[6]  = '{4'h5, 4'h0, 4'h3, 4'hF, 4'h3, 4'hF, 4'h0}; // mrmovq
    tbl[7]  = '{4'h7, 4'h6, 4'h8, 4'hF, 4'hF, 4'hF, 4'hF}; // jXX
    tbl[8]  = '{4'h8, 4'h9, 4'hA, 4'hF, 4'h4, 4'h4, 4'hF}; // call
    tbl[9]  = '{4'h9, 4'hC, 4'hD, 4'h4, 4'h4, 4'h4, 4'hF}; // ret
    tbl[10] = '{4'h1, 4'hE, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF}; // nop

    model_reset();
    idle();
    reset = 1'b0;
    repeat (3) cycle();
    chk("rst.e_valid", {31'h0, e_valid}, 32'h0);
    chk("rst.e_icode", {28'h0, e_icode}, 32'h1);
    chk("rst.ids", {16'h0, d_srcA, d_srcB, e_srcA, e_srcB}, 32'hFFFF);
    chk("rst.dst", {24'h0, e_dstE, e_dstM}, 32'hFF);
    chk("rst.stat", {30'h0, stat}, 32'h0);
    @(negedge clock) reset = 1'b1;
    #1 chk("rst.f_ready", {31'h0, f_ready}, 32'h1);

    // Back-to-back table: D holds entry k while E holds entry k-1.
    for (int k = 0; k <= 11; k++) begin
      if (k < 11) drive(1'b1, tbl[k].ic, tbl[k].ra, tbl[k].rb, 1'b0, 1'b0, 1'b0);
      else idle();
      cycle();
      check_model("tbl");
      if (k < 11) begin
        chk($sformatf("tbl%0d.d_srcA", k), {28'h0, d_srcA}, {28'h0, tbl[k].sa});
        chk($sformatf("tbl%0d.d_srcB", k), {28'h0, d_srcB}, {28'h0, tbl[k].sb});
      end
      if (k > 0) begin
        chk($sformatf("tbl%0d.e_valid", k-1), {31'h0, e_valid}, 32'h1);
        chk($sformatf("tbl%0d.e_ids", k-1), {16'h0, e_srcA, e_srcB, e_dstE, e_dstM},
            {16'h0, tbl[k-1].sa, tbl[k-1].sb, tbl[k-1].de, tbl[k-1].dm});
      end
    end

    // mrmovq held by d_stall: D keeps it, E reloads it every cycle.
    drive(1'b1, 4'h5, 4'h0, 4'h3, 1'b0, 1'b0, 1'b0);
    cycle(); check_model("stall0");
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'h6, 4'h7, 4'h8, 1'b1, 1'b0, 1'b0);
      cycle(); check_model("stall");
      chk("stall.d_srcB", {28'h0, d_srcB}, 32'h3);
      chk("stall.e_dstM", {28'h0, e_dstM}, 32'h0);
      chk("stall.f_ready", {31'h0, f_ready}, 32'h0);
    end
    drive(1'b1, 4'h6, 4'h7, 4'h8, 1'b1, 1'b1, 1'b0);
    cycle(); check_model("stallbub");
    chk("stallbub.d_srcB", {28'h0, d_srcB}, 32'h3);
    drive(1'b1, 4'h6, 4'h7, 4'h8, 1'b0, 1'b1, 1'b0);
    cycle(); check_model("dbub");
    chk("dbub.d_srcB", {28'h0, d_srcB}, 32'hF);

    // e_bubble against a halt in D: bubble wins, status untouched.
    drive(1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    cycle(); check_model("ebh0");
    idle(); e_bubble = 1'b1; d_stall = 1'b1;
    cycle(); check_model("ebh1");
    chk("ebh.stat", {30'h0, stat}, 32'h0);
    chk("ebh.e_valid", {31'h0, e_valid}, 32'h0);

    // Halt enters E, then bubbles; irmovq behind it is dropped.
    drive(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 1'b0, 1'b0);
    cycle(); check_model("halt1");
    chk("halt.e_icode", {28'h0, e_icode}, 32'h0);
    chk("halt.stat", {30'h0, stat}, 32'h1);
    chk("halt.f_ready", {31'h0, f_ready}, 32'h0);
    drive(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      cycle(); check_model("halt2");
      chk("halt.e_bubble", {31'h0, e_valid}, 32'h0);
    end
    async_reset_pulse("halt.rst");
    chk("halt.rst.stat", {30'h0, stat}, 32'h0);

    // Invalid opcode C, then asynchronous reset in mid-cycle.
    drive(1'b1, 4'hC, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
    cycle(); check_model("ins0");
    idle();
    cycle(); check_model("ins1");
    chk("ins.stat", {30'h0, stat}, 32'h2);
    chk("ins.e_valid", {31'h0, e_valid}, 32'h1);
    async_reset_pulse("ins.rst");
    chk("ins.rst.e_valid", {31'h0, e_valid}, 32'h0);
    chk("ins.rst.stat", {30'h0, stat}, 32'h0);

    // Randomized traffic; halts are rare and followed by a reset.
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] ic;
      if ($urandom_range(0, 99) < 3) ic = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'(12 + $urandom_range(0, 3));
      else ic = 4'($urandom_range(1, 11));
      drive($urandom_range(0, 9) < 8, ic, 4'($urandom), 4'($urandom),
            $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 1);
      cycle(); check_model("rnd");
      if (m_halt && $urandom_range(0, 3) == 0) async_reset_pulse("rnd.rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
